// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: up/down counter with start/pause, clear and done detection.
// Optional lap-capture register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned MAX_COUNT = 99
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       btn_lap,
    input  logic       mode,
    input  logic [6:0] preset,
    output logic [6:0] count,
    output logic [1:0] q,
    output logic       wrap,
    output logic       done,
    output logic [6:0] lap_val
);

    localparam int unsigned CW = 7;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

    localparam logic [1:0] Q_UP     = 2'b10;
    localparam logic [1:0] Q_DOWN   = 2'b00;
    localparam logic [1:0] Q_PAUSED = 2'b11;
    localparam logic [1:0] Q_IDLE   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_UP,
        S_RUN_DOWN,
        S_PAUSE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            dir_up_q, dir_up_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      q_q, q_d;
    logic            wrap_q, wrap_d;
    logic            done_q, done_d;
    logic [CW-1:0]   start_val_c;

    // Down-count start value clamped to MAX_COUNT
    assign start_val_c = (preset > MAX_C) ? MAX_C : preset;

    // State and saved-direction register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
        end
    end

    // Next-state logic; clear dominates everything, reaching zero dominates pause
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        if (btn_clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_start) begin
                        dir_up_d = mode;
                        if (mode) begin
                            state_d = S_RUN_UP;
                        end else if (start_val_c == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN_DOWN;
                        end
                    end
                end
                S_RUN_UP: begin
                    if (btn_start) state_d = S_PAUSE;
                end
                S_RUN_DOWN: begin
                    if (tick && count_q <= CW'(1)) begin
                        state_d = S_DONE;
                    end else if (btn_start) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (btn_start) state_d = dir_up_q ? S_RUN_UP : S_RUN_DOWN;
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output next-values: count arithmetic, wrap pulse, status encoding
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (btn_clr) begin
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_start) count_d = mode ? '0 : start_val_c;
                end
                S_RUN_UP: begin
                    if (tick) begin
                        if (count_q >= MAX_C) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                S_RUN_DOWN: begin
                    if (tick && count_q != '0) count_d = count_q - CW'(1);
                end
                S_DONE: begin
                    count_d = '0;
                end
                default: count_d = count_q;
            endcase
        end

        case (state_d)
            S_RUN_UP:   q_d = Q_UP;
            S_RUN_DOWN: q_d = Q_DOWN;
            S_PAUSE:    q_d = Q_PAUSED;
            default:    q_d = Q_IDLE;
        endcase
        done_d = (state_d == S_DONE);
    end

    // Output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            q_q     <= Q_IDLE;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign q     = q_q;
    assign wrap  = wrap_q;
    assign done  = done_q;

`ifdef STOPWATCH_LAP_EN
    logic [CW-1:0] lap_val_q, lap_val_d;

    // Lap capture of the pre-update count while running or paused
    always_comb begin
        lap_val_d = lap_val_q;
        if (btn_clr) begin
            lap_val_d = '0;
        end else if (btn_lap && (state_q == S_RUN_UP || state_q == S_RUN_DOWN ||
                                 state_q == S_PAUSE)) begin
            lap_val_d = count_q;
        end
    end

    // Lap register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lap_val_q <= '0;
        else       lap_val_q <= lap_val_d;
    end

    assign lap_val = lap_val_q;
`else
    logic lap_unused;
    assign lap_unused = btn_lap;
    assign lap_val    = '0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: vector table, directed corner sequences and
// randomized stimulus against a flag-based behavioural model.
module tb_stopwatch_ctrl;

    localparam int MAXC = 99;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       tick, btn_start, btn_clr, btn_lap, mode;
    logic [6:0] preset;
    logic [6:0] count;
    logic [1:0] q;
    logic       wrap, done;
    logic [6:0] lap_val;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.MAX_COUNT(MAXC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .tick      (tick),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
        .btn_lap   (btn_lap),
        .mode      (mode),
        .preset    (preset),
        .count     (count),
        .q         (q),
        .wrap      (wrap),
        .done      (done),
        .lap_val   (lap_val)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain flags and an integer count
    int m_count, m_lap;
    bit m_run, m_pause, m_done, m_up, m_wrap;

    function automatic void model_reset();
        m_count = 0; m_lap = 0; m_run = 0; m_pause = 0; m_done = 0; m_up = 1; m_wrap = 0;
    endfunction

    function automatic int model_q();
        if (m_run)   return m_up ? 2 : 0;
        if (m_pause) return 3;
        return 1;
    endfunction

    function automatic void model_step(bit t, bit s, bit c, bit l, bit md, int p);
        int start_val;
        m_wrap = 0;
        if (c) begin
            m_run = 0; m_pause = 0; m_done = 0; m_count = 0;
            if (LAP_EN) m_lap = 0;
            return;
        end
        if (LAP_EN && l && (m_run || m_pause)) m_lap = m_count;
        if (m_run) begin
            if (t) begin
                if (m_up) begin
                    if (m_count == MAXC) begin m_count = 0; m_wrap = 1; end
                    else m_count = m_count + 1;
                end else begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin m_run = 0; m_done = 1; return; end
                end
            end
            if (s) begin m_run = 0; m_pause = 1; end
        end else if (m_pause) begin
            if (s) begin m_pause = 0; m_run = 1; end
        end else if (!m_done) begin
            if (s) begin
                m_up = md;
                if (md) begin
                    m_count = 0; m_run = 1;
                end else begin
                    start_val = (p > MAXC) ? MAXC : p;
                    m_count = start_val;
                    if (start_val == 0) m_done = 1;
                    else m_run = 1;
                end
            end
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("count", int'(count), m_count);
        chk("q", int'(q), model_q());
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("done", int'(done), int'(m_done));
        chk("lap_val", int'(lap_val), m_lap);
    endtask

    // One clock: inputs held across the edge, outputs sampled 1 time unit after it
    task automatic step(input bit t, input bit s, input bit c, input bit l,
                        input bit md, input logic [6:0] p);
        tick = t; btn_start = s; btn_clr = c; btn_lap = l; mode = md; preset = p;
        @(posedge clk);
        model_step(t, s, c, l, md, int'(p));
        #1;
        cmp_model();
        tick = 0; btn_start = 0; btn_clr = 0; btn_lap = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_count", int'(count), 0);
        chk("rst_q", int'(q), 1);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lap", int'(lap_val), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        bit         tk, st, cl, md;
        logic [6:0] pre;
        int         ec, eq, ed;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit tk, input bit st, input bit cl, input bit md,
                       input int pre, input int ec, input int eq, input int ed);
        vec_t v;
        v.tk = tk; v.st = st; v.cl = cl; v.md = md; v.pre = 7'(pre);
        v.ec = ec; v.eq = eq; v.ed = ed;
        vq.push_back(v);
    endtask

    initial begin
        tick = 0; btn_start = 0; btn_clr = 0; btn_lap = 0; mode = 1; preset = '0;
        rstn = 1'b1;
        #2;
        do_reset();

        //   tk st cl md pre  count q done
        add(0, 0, 1, 1,   0,  0, 1, 0);
        add(0, 1, 0, 1,   0,  0, 2, 0);
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 1, 0, i, 2, 0);
        add(0, 0, 1, 1,   0,  0, 1, 0);
        add(0, 1, 0, 0,   3,  3, 0, 0);
        add(1, 0, 0, 0,   3,  2, 0, 0);
        add(1, 0, 0, 0,   3,  1, 0, 0);
        add(1, 0, 0, 0,   3,  0, 1, 1);
        add(0, 1, 0, 0,   3,  0, 1, 1);
        add(1, 1, 0, 1,   3,  0, 1, 1);
        add(0, 0, 1, 0,   0,  0, 1, 0);
        add(0, 1, 0, 0,   0,  0, 1, 1);
        add(0, 0, 1, 0,   0,  0, 1, 0);
        add(0, 1, 0, 0, 120, 99, 0, 0);
        add(0, 1, 0, 1,   0, 99, 3, 0);
        add(1, 0, 0, 1,   0, 99, 3, 0);
        add(0, 1, 0, 1,   0, 99, 0, 0);
        add(1, 0, 0, 1,   0, 98, 0, 0);
        add(0, 0, 1, 1,   0,  0, 1, 0);

        foreach (vq[i]) begin
            step(vq[i].tk, vq[i].st, vq[i].cl, 1'b0, vq[i].md, vq[i].pre);
            chk("tbl_count", int'(count), vq[i].ec);
            chk("tbl_q", int'(q), vq[i].eq);
            chk("tbl_done", int'(done), vq[i].ed);
        end

        // Up-count wrap at MAX_COUNT: single-cycle wrap pulse
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < MAXC; i++) step(1, 0, 0, 0, 1, 0);
        chk("pre_wrap_count", int'(count), MAXC);
        step(1, 0, 0, 0, 1, 0);
        chk("wrap_count", int'(count), 0);
        chk("wrap_pulse", int'(wrap), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("wrap_gone", int'(wrap), 0);
        chk("wrap_hold", int'(count), 0);

        // Tick and pause together, ticks ignored while paused, resume up
        step(0, 0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("pause_count", int'(count), 8);
        chk("pause_q", int'(q), 3);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        chk("paused_hold", int'(count), 8);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("resume_count", int'(count), 9);
        chk("resume_q", int'(q), 2);

        // Clear beats start and tick while running down
        step(0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 20);
        chk("down_start", int'(count), 20);
        step(1, 1, 1, 0, 0, 20);
        chk("clr_count", int'(count), 0);
        chk("clr_q", int'(q), 1);
        chk("clr_done", int'(done), 0);

        // Lap capture while running up
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        chk("lap_val", int'(lap_val), LAP_EN ? 12 : 0);
        chk("lap_count", int'(count), 13);

        // Reset mid-count discards progress and waits in IDLE
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        do_reset();
        step(1, 0, 0, 0, 1, 0);
        chk("post_rst_idle_count", int'(count), 0);
        chk("post_rst_idle_q", int'(q), 1);

        // Randomized run against the model
        for (int n = 0; n < 4000; n++) begin
            bit t, s, c, l, md;
            logic [6:0] p;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                t  = ($urandom_range(0, 1) == 0);
                s  = ($urandom_range(0, 7) == 0);
                c  = ($urandom_range(0, 39) == 0);
                l  = ($urandom_range(0, 7) == 0);
                md = ($urandom_range(0, 1) == 0);
                p  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                 : 7'($urandom_range(0, 10));
                step(t, s, c, l, md, p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL provide parameter MAX_COUNT, default 99, highest count value; legal range 1..127.
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL provide port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port tick  input  1  one-cycle count-enable strobe (e.g. 1 Hz prescaler output).
REQ-005 SHALL provide port btn_start  input  1  one-cycle start/pause toggle pulse.
REQ-006 SHALL provide port btn_clr  input  1  one-cycle clear pulse.
REQ-007 SHALL provide port btn_lap  input  1  one-cycle lap-capture pulse.
REQ-008 SHALL provide port mode  input  1  direction select: 1 = count up, 0 = count down.
REQ-009 SHALL provide port preset  input  7  down-count start value.
REQ-010 SHALL provide port count  output  7  current count value.
REQ-011 SHALL provide port q  output  2  status: 10 up, 00 down, 11 paused, 01 idle/done.
REQ-012 SHALL provide port wrap  output  1  one-cycle pulse on up-count wrap.
REQ-013 SHALL provide port done  output  1  high while in DONE.
REQ-014 SHALL provide port lap_val  output  7  last captured count.

Function
REQ-015 SHALL implement states IDLE, RUN_UP, RUN_DOWN, PAUSE, DONE; all outputs registered.
REQ-016 IDLE: count holds; btn_start with mode=1 -> RUN_UP, count<=0; with mode=0 -> RUN_DOWN, count<=min(preset, MAX_COUNT).
REQ-017 IDLE start with mode=0 and preset=0 SHALL go directly to DONE, count=0.
REQ-018 mode SHALL be sampled only on the IDLE start; changes during RUN/PAUSE are ignored.
REQ-019 RUN_UP: on tick, count<=count+1; at count=MAX_COUNT, count<=0 and wrap=1 for one cycle.
REQ-020 RUN_DOWN: on tick, count<=count-1; when count reaches 0, next state DONE.
REQ-021 Count update SHALL be visible on count the cycle after the tick cycle (1-cycle latency).
REQ-022 btn_start in RUN_UP/RUN_DOWN -> PAUSE; btn_start in PAUSE resumes the saved direction.
REQ-023 Tick and btn_start in the same RUN cycle: tick applied, then PAUSE.
REQ-024 tick SHALL be ignored in IDLE, PAUSE, DONE.
REQ-025 btn_clr in any state -> IDLE, count<=0, wrap<=0; btn_clr has priority over btn_start and tick.
REQ-026 DONE: done=1, count=0; btn_start ignored; only btn_clr leaves.
REQ-027 q SHALL encode the state per REQ-011 in the cycle after each transition.

Reset
REQ-028 rstn low SHALL immediately force IDLE, count=0, q=01, wrap=0, done=0, lap_val=0, saved direction=up.
REQ-029 Reset assertion mid-count SHALL discard all progress; after deassertion the block waits in IDLE for btn_start.

Configuration
REQ-030 Macro STOPWATCH_LAP_EN SHALL gate the lap feature.
REQ-031 With STOPWATCH_LAP_EN defined: btn_lap in RUN_UP/RUN_DOWN/PAUSE captures count (pre-update value) into lap_val; btn_clr zeroes lap_val.
REQ-032 Without STOPWATCH_LAP_EN: btn_lap ignored, lap_val tied to 0, no lap register synthesized.

Verification
REQ-033 rstn low, mode=1, btn_start, 5 ticks -> count=5, q=10.
REQ-034 MAX_COUNT=99, running up at 99, tick -> count=0, wrap high exactly one cycle.
REQ-035 mode=0, preset=3, btn_start, 3 ticks -> count 3,2,1,0, then done=1, q=01; further btn_start -> no change.
REQ-036 Running up at 7, btn_start+tick same cycle -> count=8, q=11; 4 ticks -> count=8; btn_start, 1 tick -> count=9, q=10.
REQ-037 Running down at 20, btn_clr+btn_start+tick same cycle -> count=0, q=01, state IDLE.
REQ-038 STOPWATCH_LAP_EN defined, running up at 12, btn_lap -> lap_val=12, count continues; undefined -> lap_val stays 0.
